// File: rtl/sme_pkg.sv
// Shared types and constants for the SME job sequencer: FSM states, beat
// format, per-job length limits and the WAIT watchdog limit.
package sme_pkg;

  localparam int MAX_STR = 32;
  localparam int MAX_PAT = 8;

  // Watchdog terminal count (cycles in WAIT) when SME_SEQ_TIMEOUT_EN is defined.
  localparam int          TIMEOUT_CYC   = 1023;
  localparam logic [4:0]  TIMEOUT_INDEX = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STR  = 2'd1,
    S_PAT  = 2'd2,
    S_WAIT = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic       kind;  // 0 = string char, 1 = pattern char
    logic       last;
    logic [7:0] data;
  } beat_t;

endpackage

// File: rtl/sme_beat_fifo.sv
// Synchronous FIFO of beat_t entries with full/empty/count status.
// Pushes while full and pops while empty are ignored.
module sme_beat_fifo
  import sme_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  beat_t                    wr_beat,
  input  logic                     pop,
  output beat_t                    rd_beat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  beat_t         mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_beat;
  end

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_beat = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sme_job_sequencer.sv
// Buffers complete jobs of tagged beats and replays them to the SME as
// isstring/ispattern bursts, then forwards the SME result with a job ID.
// Optional WAIT watchdog: define SME_SEQ_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a complete job in the FIFO
// STR    | popping string beats to the SME
// PAT    | popping pattern beats until the in_last beat
// WAIT   | burst done, waiting for the SME result
module sme_job_sequencer
  import sme_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int MAX_STR    = sme_pkg::MAX_STR,
  parameter int MAX_PAT    = sme_pkg::MAX_PAT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_kind,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic [7:0] res_job_id,
  output logic       err_fmt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(MAX_STR + 1);
  localparam int PW = $clog2(MAX_PAT + 1);

  seq_state_t    state;
  seq_state_t    state_nxt;
  beat_t         in_beat;
  beat_t         head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          push;
  logic          pop;
  logic [CW-1:0] job_cnt;
  logic          job_ready;
  logic [SW-1:0] str_cnt;
  logic [PW-1:0] pat_cnt;
  logic          seen_pat;
  logic          fmt_bad;
  logic          wd_expired;
  logic          res_fire;
  logic [7:0]    job_id;

  assign in_beat  = '{kind: in_kind, last: in_last, data: in_data};
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  sme_beat_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_beat (in_beat),
    .pop     (pop),
    .rd_beat (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Complete jobs buffered; push of in_last and pop of a last beat cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      job_cnt <= '0;
    end else begin
      case ({push && in_last, pop && head.last})
        2'b10:   job_cnt <= job_cnt + 1'b1;
        2'b01:   job_cnt <= job_cnt - 1'b1;
        default: job_cnt <= job_cnt;
      endcase
    end
  end

  assign job_ready = (job_cnt != '0) && (fifo_count != '0);

  // Per-job input format checking on the upstream side.
  always_comb begin
    fmt_bad = 1'b0;
    if (push) begin
      if (!in_kind) begin
        if (seen_pat || in_last || (str_cnt == SW'(MAX_STR))) fmt_bad = 1'b1;
      end else if (pat_cnt == PW'(MAX_PAT)) begin
        fmt_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      str_cnt  <= '0;
      pat_cnt  <= '0;
      seen_pat <= 1'b0;
    end else if (push) begin
      if (in_last) begin
        str_cnt  <= '0;
        pat_cnt  <= '0;
        seen_pat <= 1'b0;
      end else if (!in_kind) begin
        if (str_cnt != SW'(MAX_STR)) str_cnt <= str_cnt + 1'b1;
      end else begin
        seen_pat <= 1'b1;
        if (pat_cnt != PW'(MAX_PAT)) pat_cnt <= pat_cnt + 1'b1;
      end
    end
  end

`ifdef SME_SEQ_TIMEOUT_EN
  logic [9:0] wd_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= 10'(TIMEOUT_CYC);
    end else if (state != S_WAIT) begin
      wd_cnt <= 10'(TIMEOUT_CYC);
    end else if (wd_cnt != '0) begin
      wd_cnt <= wd_cnt - 1'b1;
    end
  end

  assign wd_expired = (state == S_WAIT) && (wd_cnt == '0) && !sme_valid;
`else
  assign wd_expired = 1'b0;
`endif

  assign res_fire = (state == S_WAIT) && (sme_valid || wd_expired);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // STR and PAT both pop the head; the head kind selects the next state so a
  // string-to-pattern change costs no gap cycle.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (job_ready) state_nxt = head.kind ? S_PAT : S_STR;
      end
      S_STR, S_PAT: begin
        pop = !fifo_empty;
        if (head.last)      state_nxt = S_WAIT;
        else if (head.kind) state_nxt = S_PAT;
        else                state_nxt = S_STR;
      end
      S_WAIT: begin
        if (res_fire) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isstring   <= 1'b0;
      ispattern  <= 1'b0;
      chardata   <= '0;
      res_valid  <= 1'b0;
      res_match  <= 1'b0;
      res_index  <= '0;
      res_job_id <= '0;
      job_id     <= '0;
      err_fmt    <= 1'b0;
    end else begin
      isstring  <= pop && !head.kind;
      ispattern <= pop && head.kind;
      if (pop) chardata <= head.data;
      res_valid <= res_fire;
      if (res_fire) begin
        res_match  <= sme_valid ? sme_match : 1'b0;
        res_index  <= sme_valid ? sme_index : TIMEOUT_INDEX;
        res_job_id <= job_id;
        job_id     <= job_id + 1'b1;
      end
      err_fmt <= err_fmt | fmt_bad | wd_expired;
    end
  end

endmodule

// File: tb/tb_sme_job_sequencer.sv
// Scoreboard bench for sme_job_sequencer: expected beats and results are
// queued at stimulus / SME-response time and compared at the DUT outputs.
module tb_sme_job_sequencer;
  import sme_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_kind = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       sme_valid = 1'b0;
  logic       sme_match = 1'b0;
  logic [4:0] sme_index = '0;
  logic       res_valid;
  logic       res_match;
  logic [4:0] res_index;
  logic [7:0] res_job_id;
  logic       err_fmt;

  int vectors = 0;
  int miscompares = 0;

  beat_t       exp_beats[$];
  logic [13:0] exp_res[$];   // {match, index[4:0], job_id[7:0]}
  logic [5:0]  rsp_q[$];     // {match, index} for upcoming SME responses
  logic [7:0]  exp_id = '0;
  bit          busy = 0, pend_rsp = 0, in_burst = 0, sme_auto = 1, stray_sme = 0;
  int          rsp_wait = 0;
  int          cyc = 0, last_cyc = 0, res_cyc = 0;

  sme_job_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_kind    (in_kind),
    .in_last    (in_last),
    .chardata   (chardata),
    .isstring   (isstring),
    .ispattern  (ispattern),
    .sme_valid  (sme_valid),
    .sme_match  (sme_match),
    .sme_index  (sme_index),
    .res_valid  (res_valid),
    .res_match  (res_match),
    .res_index  (res_index),
    .res_job_id (res_job_id),
    .err_fmt    (err_fmt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor plus SME responder model.
  always @(negedge clk) begin : mon
    beat_t       b;
    logic [13:0] e;
    logic [5:0]  r;
    cyc++;
    if (!reset) begin
      if (isstring || ispattern) begin
        check("no_overlap", busy, 0);
        if (exp_beats.size() == 0) begin
          check("beat_extra", 1, 0);
        end else begin
          b = exp_beats.pop_front();
          check("beat_kind", {isstring, ispattern}, {!b.kind, b.kind});
          check("chardata", chardata, b.data);
          in_burst = !b.last;
          if (b.last) begin
            busy = 1; pend_rsp = 1; rsp_wait = 2; last_cyc = cyc;
          end
        end
      end else if (in_burst) begin
        check("burst_gap", 0, 1);
        in_burst = 0;
      end
      if (res_valid) begin
        res_cyc = cyc;
        if (exp_res.size() == 0) begin
          check("res_extra", 1, 0);
        end else begin
          e = exp_res.pop_front();
          check("res_match", res_match, e[13]);
          check("res_index", res_index, e[12:8]);
          check("res_job_id", res_job_id, e[7:0]);
        end
        busy = 0;
      end
      sme_valid = 1'b0;
      if (stray_sme) begin
        sme_valid = 1'b1; sme_match = 1'b1; sme_index = 5'd7;
        stray_sme = 0;
      end else if (pend_rsp && sme_auto) begin
        if (rsp_wait == 0) begin
          r = (rsp_q.size() != 0) ? rsp_q.pop_front() : 6'($urandom);
          sme_valid = 1'b1; sme_match = r[5]; sme_index = r[4:0];
          exp_res.push_back({r, exp_id});
          exp_id++;
          pend_rsp = 0;
        end else begin
          rsp_wait--;
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_kind = 1'b0; in_last = 1'b0; in_data = '0;
    exp_beats.delete(); exp_res.delete(); rsp_q.delete();
    exp_id = '0; busy = 0; pend_rsp = 0; in_burst = 0; stray_sme = 0;
    sme_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_beat(input logic k, input logic l, input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1; in_kind = k; in_last = l; in_data = d;
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("push_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_beats.push_back('{kind: k, last: l, data: d});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_job(input string s, input string p);
    for (int i = 0; i < s.len(); i++) push_beat(1'b0, 1'b0, s[i]);
    for (int i = 0; i < p.len(); i++) push_beat(1'b1, i == p.len() - 1, p[i]);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_beats.size() != 0 || exp_res.size() != 0 || busy || pend_rsp) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(tag, n < 5000, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int n;
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_isstring", isstring, 0);
    check("rst_ispattern", ispattern, 0);
    check("rst_chardata", chardata, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_job_id", res_job_id, 0);
    check("rst_err_fmt", err_fmt, 0);

    // Basic job: "ab" string, "b" pattern, SME says match at index 1.
    rsp_q.push_back({1'b1, 5'd1});
    push_job("ab", "b");
    wait_drain("t1_drain");

    // Back-to-back jobs, the second pattern-only.
    push_job("xy", "y");
    push_job("", "^a*");
    wait_drain("t2_drain");

    // sme_valid outside WAIT must not produce a result.
    @(negedge clk);
    stray_sme = 1;
    repeat (4) @(negedge clk);
    check("stray_no_err", err_fmt, 0);

    // Fill the FIFO while the SME is held off.
    sme_auto = 0;
    push_job("", "z");
    n = 0;
    while (!busy && n < 200) begin @(negedge clk); n++; end
    check("blocker_in_wait", busy, 1);
    for (int i = 0; i < 64; i++) begin
      check("ready_before_full", in_ready, 1);
      push_beat((i % 8) >= 4, (i % 8) == 7, 8'(8'h40 + i));
    end
    check("ready_at_full", in_ready, 0);
    @(negedge clk);
    check("ready_held_full", in_ready, 0);
    sme_auto = 1;
    push_beat(1'b1, 1'b1, 8'h21);
    wait_drain("full_drain");

    // Reset during a pattern burst.
    do_reset();
    push_job("1234", "abcd");
    n = 0;
    while (!ispattern && n < 200) begin @(negedge clk); n++; end
    check("saw_pattern", ispattern, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_isstring", isstring, 0);
    check("mid_rst_ispattern", ispattern, 0);
    check("mid_rst_chardata", chardata, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    do_reset();
    push_job("q", "r");
    wait_drain("post_rst_drain");

    // Format errors.
    do_reset();
    for (int i = 0; i < 32; i++) push_beat(1'b0, 1'b0, 8'(8'h61 + i % 26));
    check("err_32_str", err_fmt, 0);
    push_beat(1'b0, 1'b0, 8'h7a);
    check("err_33_str", err_fmt, 1);
    push_beat(1'b1, 1'b1, 8'h2e);
    wait_drain("e1_drain");

    do_reset();
    push_beat(1'b1, 1'b0, 8'h61);
    check("err_pat_ok", err_fmt, 0);
    push_beat(1'b0, 1'b0, 8'h62);
    check("err_str_after_pat", err_fmt, 1);
    push_beat(1'b1, 1'b1, 8'h63);
    wait_drain("e2_drain");

    do_reset();
    for (int i = 0; i < 8; i++) push_beat(1'b1, 1'b0, 8'(8'h30 + i));
    check("err_8_pat", err_fmt, 0);
    push_beat(1'b1, 1'b1, 8'h39);
    check("err_9_pat", err_fmt, 1);
    wait_drain("e3_drain");

    do_reset();
    push_beat(1'b0, 1'b1, 8'h73);
    check("err_last_on_str", err_fmt, 1);
    wait_drain("e4_drain");

`ifdef SME_SEQ_TIMEOUT_EN
    do_reset();
    sme_auto = 0;
    push_job("", "t");
    n = 0;
    while (!busy && n < 200) begin @(negedge clk); n++; end
    pend_rsp = 0;
    exp_res.push_back({1'b0, 5'd31, exp_id});
    exp_id++;
    n = 0;
    while (busy && n < 1200) begin @(negedge clk); n++; end
    check("timeout_fired", busy, 0);
    check("timeout_latency", res_cyc - last_cyc, 1024);
    check("timeout_err_fmt", err_fmt, 1);
    sme_auto = 1;
`endif

    repeat (3) @(negedge clk);
    check("beats_left", exp_beats.size(), 0);
    check("results_left", exp_res.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
